// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
// Shared types and constants for the Baby / SPI loader RAM arbiter.
//   arb_state_e    : ownership FSM states
//   OWNER_BABY/SPI : encoding of owner_o and of the access-owner select
//   DEF_*          : default geometry of the shared word RAM
// ---------------------------------------------------------------------------
package ram_arb_pkg;

  localparam int DEF_ADDR_W       = 5;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_HALT_TIMEOUT = 1024;

  localparam logic OWNER_BABY = 1'b0;
  localparam logic OWNER_SPI  = 1'b1;

  typedef enum logic [1:0] {
    BABY_OWN  = 2'd0,
    HALT_WAIT = 2'd1,
    SPI_OWN   = 2'd2,
    RELEASE   = 2'd3
  } arb_state_e;

  // The Baby may issue in every state except SPI_OWN. In RELEASE the issue
  // only becomes visible on the RAM port after the turnaround cycle.
  function automatic logic baby_may_issue(input arb_state_e state);
    return (state != SPI_OWN);
  endfunction

  // The SPI side only issues while it owns the RAM and its session is open,
  // so no new access can start on the edge that leaves SPI_OWN.
  function automatic logic spi_may_issue(input arb_state_e state, input logic cs);
    return (state == SPI_OWN) && cs;
  endfunction

endpackage

// File: rtl/ram_access_seq.sv
// ---------------------------------------------------------------------------
// ram_access_seq
// Single-cycle access sequencer for a synchronous RAM port.
//   req_i/sel_i/we_i/addr_i/wdata_i : owner-muxed request (sel_i = who)
//   ram_en_o/ram_we_o/ram_addr_o/ram_data_o : registered RAM port
//   ram_data_i      : RAM read data, valid the cycle after ram_en_o
//   baby_ack_o/spi_ack_o   : one-cycle completion pulses
//   baby_data_o/spi_data_o : read data, held until the next read completes
//   busy_o          : an access is being issued to the RAM this cycle
// Timing: request sampled at edge k -> enable during the following cycle ->
// ack and read data during the cycle after that. The ack cycle is already
// idle, so a request held through it starts the next access (1 per 2 cycles).
// ---------------------------------------------------------------------------
module ram_access_seq
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              sel_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic              baby_ack_o,
  output logic [DATA_W-1:0] baby_data_o,
  output logic              spi_ack_o,
  output logic [DATA_W-1:0] spi_data_o,
  output logic              busy_o
);

  logic              en_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              sel_r;
  logic              baby_ack_r;
  logic              spi_ack_r;
  logic              ack_rd_r;
  logic [DATA_W-1:0] baby_hold_r;
  logic [DATA_W-1:0] spi_hold_r;
  logic              issue_s;

  // A new access may start whenever the RAM port is not being driven.
  always_comb begin
    issue_s = 1'b0;
    if (req_i && !en_r) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Issue, acknowledge and read-data hold registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      en_r        <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      sel_r       <= OWNER_BABY;
      baby_ack_r  <= 1'b0;
      spi_ack_r   <= 1'b0;
      ack_rd_r    <= 1'b0;
      baby_hold_r <= {DATA_W{1'b0}};
      spi_hold_r  <= {DATA_W{1'b0}};
    end else begin
      if (issue_s) begin
        en_r    <= 1'b1;
        we_r    <= we_i;
        addr_r  <= addr_i;
        wdata_r <= wdata_i;
        sel_r   <= sel_i;
      end else begin
        // Address and data stay put so the RAM pins only toggle on issue.
        en_r <= 1'b0;
        we_r <= 1'b0;
      end
      baby_ack_r <= en_r && (sel_r == OWNER_BABY);
      spi_ack_r  <= en_r && (sel_r == OWNER_SPI);
      ack_rd_r   <= en_r && !we_r;
      if (baby_ack_r && ack_rd_r) begin
        baby_hold_r <= ram_data_i;
      end
      if (spi_ack_r && ack_rd_r) begin
        spi_hold_r <= ram_data_i;
      end
    end
  end

  // During a read ack the RAM output register is presented directly; the
  // hold register takes over from the next cycle on.
  always_comb begin
    if (baby_ack_r && ack_rd_r) begin
      baby_data_o = ram_data_i;
    end else begin
      baby_data_o = baby_hold_r;
    end
    if (spi_ack_r && ack_rd_r) begin
      spi_data_o = ram_data_i;
    end else begin
      spi_data_o = spi_hold_r;
    end
  end

  assign ram_en_o   = en_r;
  assign ram_we_o   = we_r;
  assign ram_addr_o = addr_r;
  assign ram_data_o = wdata_r;
  assign baby_ack_o = baby_ack_r;
  assign spi_ack_o  = spi_ack_r;
  assign busy_o     = en_r;

endmodule

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Ownership arbiter for the shared word RAM between the Baby CPU and the SPI
// loader. An SPI session asks the Baby to halt, waits (bounded) for the halt
// acknowledge, hands the RAM to SPI, and gives it back via one idle cycle.
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   baby_* / spi_*         : per-requester level req / one-cycle ack access
//   baby_halt_o/halted_i   : halt handshake with the Baby core
//   spi_cs_i               : SPI session active (already synchronised)
//   ram_*                  : synchronous RAM port
//   owner_o                : 0 = Baby, 1 = SPI
//   timeout_o              : sticky halt-handshake timeout flag
// ---------------------------------------------------------------------------
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int HALT_TIMEOUT = DEF_HALT_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              baby_req_i,
  input  logic              baby_we_i,
  input  logic [ADDR_W-1:0] baby_addr_i,
  input  logic [DATA_W-1:0] baby_data_i,
  output logic              baby_ack_o,
  output logic [DATA_W-1:0] baby_data_o,
  output logic              baby_halt_o,
  input  logic              baby_halted_i,
  input  logic              spi_cs_i,
  input  logic              spi_req_i,
  input  logic              spi_we_i,
  input  logic [ADDR_W-1:0] spi_addr_i,
  input  logic [DATA_W-1:0] spi_data_i,
  output logic              spi_ack_o,
  output logic [DATA_W-1:0] spi_data_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic              owner_o,
  output logic              timeout_o
);

  localparam int CNT_W = (HALT_TIMEOUT > 2) ? $clog2(HALT_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALT_TIMEOUT - 1);

  arb_state_e        state_r;
  logic              owner_r;
  logic              halt_r;
  logic              timeout_r;
  logic              abandon_r;
  logic [CNT_W-1:0]  cnt_r;

  logic              busy_s;
  logic              req_s;
  logic              sel_s;
  logic              we_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] wdata_s;

  // Route the requester allowed to issue in the current state to the sequencer.
  always_comb begin
    req_s   = 1'b0;
    sel_s   = OWNER_BABY;
    we_s    = 1'b0;
    addr_s  = {ADDR_W{1'b0}};
    wdata_s = {DATA_W{1'b0}};
    if (spi_may_issue(state_r, spi_cs_i)) begin
      req_s   = spi_req_i;
      sel_s   = OWNER_SPI;
      we_s    = spi_we_i;
      addr_s  = spi_addr_i;
      wdata_s = spi_data_i;
    end else if (baby_may_issue(state_r)) begin
      req_s   = baby_req_i;
      sel_s   = OWNER_BABY;
      we_s    = baby_we_i;
      addr_s  = baby_addr_i;
      wdata_s = baby_data_i;
    end else begin
      req_s   = 1'b0;
      sel_s   = OWNER_BABY;
    end
  end

  // Ownership FSM with halt request, timeout counter and owner flag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r   <= BABY_OWN;
      owner_r   <= OWNER_BABY;
      halt_r    <= 1'b0;
      timeout_r <= 1'b0;
      abandon_r <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
    end else begin
      // A timed-out session is not retried until spi_cs_i has dropped;
      // otherwise a still-open session would re-halt the Baby immediately.
      if (!spi_cs_i) begin
        abandon_r <= 1'b0;
      end
      case (state_r)
        BABY_OWN: begin
          if (spi_cs_i && !abandon_r) begin
            state_r <= HALT_WAIT;
            halt_r  <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        HALT_WAIT: begin
          if (!spi_cs_i) begin
            state_r <= BABY_OWN;
            halt_r  <= 1'b0;
          end else if (baby_halted_i && !busy_s) begin
            state_r   <= SPI_OWN;
            owner_r   <= OWNER_SPI;
            timeout_r <= 1'b0;
          end else if (cnt_r == CNT_LAST) begin
            state_r   <= BABY_OWN;
            halt_r    <= 1'b0;
            timeout_r <= 1'b1;
            abandon_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        SPI_OWN: begin
          if (!spi_cs_i && !busy_s) begin
            state_r <= RELEASE;
            owner_r <= OWNER_BABY;
            halt_r  <= 1'b0;
          end
        end
        RELEASE: begin
          state_r <= BABY_OWN;
        end
        default: begin
          state_r <= BABY_OWN;
          owner_r <= OWNER_BABY;
          halt_r  <= 1'b0;
        end
      endcase
    end
  end

  ram_access_seq #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_seq (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_s),
    .sel_i       (sel_s),
    .we_i        (we_s),
    .addr_i      (addr_s),
    .wdata_i     (wdata_s),
    .ram_en_o    (ram_en_o),
    .ram_we_o    (ram_we_o),
    .ram_addr_o  (ram_addr_o),
    .ram_data_o  (ram_data_o),
    .ram_data_i  (ram_data_i),
    .baby_ack_o  (baby_ack_o),
    .baby_data_o (baby_data_o),
    .spi_ack_o   (spi_ack_o),
    .spi_data_o  (spi_data_o),
    .busy_o      (busy_s)
  );

  assign owner_o     = owner_r;
  assign baby_halt_o = halt_r;
  assign timeout_o   = timeout_r;

endmodule
